bbox_extractor: RTL

Produces the per-frame bounding-box list consumed by the box-overlay stage. Scans a binary foreground mask stream, which is pixel-aligned with the camera stream. Merges horizontal foreground runs into up to 16 box slots. At end of frame, publishes them as a 16 x 43-bit pos_data array in the same packed format the overlay stage reads.

---
 rtl/bbox_extractor.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bbox_extractor.sv
// bbox_extractor: scans a raster-order binary foreground mask, merges
// horizontal foreground runs into up to 16 bounding-box slots and publishes
// the box list once per frame in the overlay stage's packed 43-bit format:
//   [42] flag, [41:32] ymax, [31:21] xmax, [20:11] ymin, [10:0] xmin
// Optional build macro: BOX_SIZE_FILTER_EN. When defined, boxes narrower
// than MIN_W or shorter than MIN_H publish with flag 0 but keep their
// coordinates. When undefined, every active slot publishes with flag 1.
module bbox_extractor #(
  parameter int H_PIXEL   = 1024,
  parameter int V_PIXEL   = 768,
  parameter int MERGE_GAP = 4,
  parameter int MIN_W     = 4,
  parameter int MIN_H     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              pre_wr_en,
  input  logic              pre_hs,
  input  logic              pre_vs,
  input  logic              bin_data,
  output logic [15:0][42:0] pos_data,
  output logic              pos_valid,
  output logic [4:0]        obj_cnt,
  output logic              overflow
);

  localparam int         NSLOT  = 16;
  localparam logic [10:0] X_LAST = 11'(H_PIXEL - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_PIXEL - 1);
  localparam logic [11:0] GAP_X  = 12'(MERGE_GAP);
  localparam logic [10:0] GAP_Y  = 11'(MERGE_GAP);
  localparam logic [1:0]  ST_SCAN    = 2'd0;
  localparam logic [1:0]  ST_FLUSH   = 2'd1;
  localparam logic [1:0]  ST_PUBLISH = 2'd2;

  logic [1:0]  state_reg;
  logic        vs_d_reg;
  logic [10:0] cnt_x_reg;
  logic [9:0]  cnt_y_reg;
  logic        run_open_reg, run_open_next;
  logic [10:0] run_xs_reg, run_xs_next;
  logic        pend_valid_reg;
  logic [10:0] pend_xs_reg, pend_xe_reg;
  logic [9:0]  pend_y_reg;
  logic        slot_act_reg  [NSLOT];
  logic [10:0] slot_xmin_reg [NSLOT];
  logic [10:0] slot_xmax_reg [NSLOT];
  logic [9:0]  slot_ymin_reg [NSLOT];
  logic [9:0]  slot_ymax_reg [NSLOT];
  logic        overflow_w_reg;
  logic [15:0][42:0] pos_data_reg;
  logic        pos_valid_reg;
  logic [4:0]  obj_cnt_reg;
  logic        overflow_reg;

  // Line sync carries no information the pixel counters do not already have.
  logic unused_hs;
  assign unused_hs = pre_hs;

  logic vs_rise, frame_end, discard, publish;
  assign vs_rise   = pre_vs & ~vs_d_reg;
  assign frame_end = (state_reg == ST_SCAN) && pre_wr_en && !vs_rise &&
                     (cnt_x_reg == X_LAST) && (cnt_y_reg == Y_LAST);
  // A frame sync in the middle of a frame throws the partial frame away.
  assign discard   = vs_rise && (state_reg == ST_SCAN) &&
                     ((cnt_x_reg != 11'd0) || (cnt_y_reg != 10'd0));
  assign publish   = (state_reg == ST_PUBLISH);

  // Run open/close detection on the current pixel.
  logic        run_close;
  logic [10:0] close_xs, close_xe;
  always_comb begin
    run_close     = 1'b0;
    close_xs      = run_xs_reg;
    close_xe      = cnt_x_reg - 11'd1;
    run_open_next = run_open_reg;
    run_xs_next   = run_xs_reg;
    if (vs_rise) begin
      run_open_next = 1'b0;
    end else if (pre_wr_en) begin
      if (bin_data) begin
        if (!run_open_reg || (cnt_x_reg == 11'd0)) begin
          run_xs_next = cnt_x_reg;
          close_xs    = cnt_x_reg;
        end
        if (cnt_x_reg == X_LAST) begin
          run_close     = 1'b1;
          close_xe      = X_LAST;
          run_open_next = 1'b0;
        end else begin
          run_open_next = 1'b1;
        end
      end else if (run_open_reg) begin
        run_close     = 1'b1;
        run_open_next = 1'b0;
      end
    end
  end

  // Per-slot match test (1 bit wider so the gap addition cannot wrap),
  // size test and published entry.
  logic [NSLOT-1:0] slot_hit, slot_flag, size_ok;
  logic [42:0]      slot_entry [NSLOT];
  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      assign slot_hit[gi] = slot_act_reg[gi] &&
        ({1'b0, pend_xs_reg} <= {1'b0, slot_xmax_reg[gi]} + GAP_X) &&
        ({1'b0, pend_xe_reg} + GAP_X >= {1'b0, slot_xmin_reg[gi]}) &&
        ({1'b0, pend_y_reg} <= {1'b0, slot_ymax_reg[gi]} + GAP_Y);
      assign size_ok[gi] =
        ({1'b0, slot_xmax_reg[gi]} + 12'd1 >= {1'b0, slot_xmin_reg[gi]} + 12'(MIN_W)) &&
        ({1'b0, slot_ymax_reg[gi]} + 11'd1 >= {1'b0, slot_ymin_reg[gi]} + 11'(MIN_H));
`ifdef BOX_SIZE_FILTER_EN
      assign slot_flag[gi] = slot_act_reg[gi] && size_ok[gi];
`else
      assign slot_flag[gi] = slot_act_reg[gi];
`endif
      assign slot_entry[gi] = slot_act_reg[gi] ?
        {slot_flag[gi], slot_ymax_reg[gi], slot_xmax_reg[gi],
         slot_ymin_reg[gi], slot_xmin_reg[gi]} : 43'd0;
    end
  endgenerate

`ifndef BOX_SIZE_FILTER_EN
  logic unused_size_ok;
  assign unused_size_ok = &{1'b0, size_ok};
`endif

  // Lowest-index matching slot, lowest-index free slot, and flag popcount.
  logic       hit_any, free_any;
  logic [3:0] hit_idx, free_idx;
  logic [4:0] flag_cnt;
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = 4'd0;
    free_any = 1'b0;
    free_idx = 4'd0;
    flag_cnt = 5'd0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit_any = 1'b1;
        hit_idx = 4'(i);
      end
      if (!slot_act_reg[i]) begin
        free_any = 1'b1;
        free_idx = 4'(i);
      end
    end
    for (int i = 0; i < NSLOT; i++) flag_cnt = flag_cnt + 5'(slot_flag[i]);
  end

  // Frame-sync edge detect and raster pixel counters.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vs_d_reg  <= 1'b0;
      cnt_x_reg <= 11'd0;
      cnt_y_reg <= 10'd0;
    end else begin
      vs_d_reg <= pre_vs;
      if (vs_rise) begin
        cnt_x_reg <= 11'd0;
        cnt_y_reg <= 10'd0;
      end else if (pre_wr_en) begin
        if (cnt_x_reg == X_LAST) begin
          cnt_x_reg <= 11'd0;
          cnt_y_reg <= (cnt_y_reg == Y_LAST) ? 10'd0 : cnt_y_reg + 10'd1;
        end else begin
          cnt_x_reg <= cnt_x_reg + 11'd1;
        end
      end
    end
  end

  // Open-run tracking and the one-entry pending run register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      run_open_reg   <= 1'b0;
      run_xs_reg     <= 11'd0;
      pend_valid_reg <= 1'b0;
      pend_xs_reg    <= 11'd0;
      pend_xe_reg    <= 11'd0;
      pend_y_reg     <= 10'd0;
    end else begin
      run_open_reg   <= run_open_next;
      run_xs_reg     <= run_xs_next;
      pend_valid_reg <= run_close;
      if (run_close) begin
        pend_xs_reg <= close_xs;
        pend_xe_reg <= close_xe;
        pend_y_reg  <= cnt_y_reg;
      end
    end
  end

  // Slot table: merge or allocate the pending run; cleared on publish/discard.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      overflow_w_reg <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        slot_act_reg[i]  <= 1'b0;
        slot_xmin_reg[i] <= 11'd0;
        slot_xmax_reg[i] <= 11'd0;
        slot_ymin_reg[i] <= 10'd0;
        slot_ymax_reg[i] <= 10'd0;
      end
    end else if (publish || discard) begin
      overflow_w_reg <= 1'b0;
      for (int i = 0; i < NSLOT; i++) slot_act_reg[i] <= 1'b0;
    end else if (pend_valid_reg) begin
      if (hit_any) begin
        if (pend_xs_reg < slot_xmin_reg[hit_idx]) slot_xmin_reg[hit_idx] <= pend_xs_reg;
        if (pend_xe_reg > slot_xmax_reg[hit_idx]) slot_xmax_reg[hit_idx] <= pend_xe_reg;
        slot_ymax_reg[hit_idx] <= pend_y_reg;
      end else if (free_any) begin
        slot_act_reg[free_idx]  <= 1'b1;
        slot_xmin_reg[free_idx] <= pend_xs_reg;
        slot_xmax_reg[free_idx] <= pend_xe_reg;
        slot_ymin_reg[free_idx] <= pend_y_reg;
        slot_ymax_reg[free_idx] <= pend_y_reg;
      end else begin
        overflow_w_reg <= 1'b1;
      end
    end
  end

  // Frame sequencer: SCAN -> FLUSH -> PUBLISH -> SCAN.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= ST_SCAN;
    end else begin
      case (state_reg)
        ST_SCAN:  if (frame_end) state_reg <= ST_FLUSH;
        ST_FLUSH: state_reg <= ST_PUBLISH;
        default:  state_reg <= ST_SCAN;
      endcase
    end
  end

  // Published outputs; held until the next publish.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pos_data_reg  <= '0;
      pos_valid_reg <= 1'b0;
      obj_cnt_reg   <= 5'd0;
      overflow_reg  <= 1'b0;
    end else begin
      pos_valid_reg <= publish;
      if (publish) begin
        for (int i = 0; i < NSLOT; i++) pos_data_reg[i] <= slot_entry[i];
        obj_cnt_reg  <= flag_cnt;
        overflow_reg <= overflow_w_reg;
      end
    end
  end

  assign pos_data  = pos_data_reg;
  assign pos_valid = pos_valid_reg;
  assign obj_cnt   = obj_cnt_reg;
  assign overflow  = overflow_reg;

endmodule
